rgb_to_bayer_mosaic: RTL and testbench
======================================

// Module: rgb_to_bayer_mosaic
// PURPOSE
//  Re-mosaics a raster RGB pixel stream into a single-channel 12-bit Bayer stream with X/Y coordinates.
//  Its output interface is the same one the Bayer-to-RGB demosaic consumes.
//  Injects synthetic or stored RGB frames (test patterns, SDRAM playback) into the demosaic path.
//  Also provides frame/line sync recovery and a frame counter.
// PARAMETERS
//  VIDEO_W   800    active pixels per line
//  VIDEO_H   600    active lines per frame
//  PHASE     2'b00  {y_flip,x_flip}: XORed into {Y[0],X[0]} before channel select
// PORTS
//  BAYER_CLK        in   1   single clock; all logic rising-edge
//  reset            in   1   synchronous, active-high reset
//  RGB_R            in   12  red sample
//  RGB_G            in   12  green sample
//  RGB_B            in   12  blue sample
//  RGB_VALID        in   1   pixel present this cycle (no backpressure)
//  RGB_SOF          in   1   qualifies RGB_VALID: pixel is (0,0) of a frame
//  ERR_CLR          in   1   clears ERR_SYNC
//  BAYER_DATA       out  12  mosaiced sample
//  BAYER_X          out  12  column of BAYER_DATA
//  BAYER_Y          out  12  row of BAYER_DATA
//  BAYER_VALID      out  1   BAYER_DATA/X/Y valid
//  BAYER_WIDTH      out  12  constant VIDEO_W
//  BAYER_HEIGHT     out  12  constant VIDEO_H
//  FRAME_COUNT      out  20  completed frames, wraps at 2^20
//  ERR_SYNC         out  1   sticky: SOF arrived mid-frame
// BEHAVIOUR
//  Reset:
//   - State IDLE; x_cnt=y_cnt=0.
//   - BAYER_DATA/X/Y/VALID=0, FRAME_COUNT=0, ERR_SYNC=0.
//   - Reset has priority over all inputs; asserting it mid-frame abandons the frame and does not count it.
//  FSM: IDLE, ACTIVE.
//   - IDLE: RGB_VALID without RGB_SOF is dropped (BAYER_VALID=0). RGB_VALID&RGB_SOF emits (0,0) -> ACTIVE.
//   - ACTIVE, RGB_VALID & ~RGB_SOF: emit (x_cnt,y_cnt).
//     - If x_cnt==VIDEO_W-1: x_cnt=0, y_cnt++.
//     - Otherwise: x_cnt++.
//   - ACTIVE, last pixel (VIDEO_W-1,VIDEO_H-1) emitted: FRAME_COUNT++, counters->0, -> IDLE.
//   - ACTIVE, RGB_VALID&RGB_SOF while (x_cnt,y_cnt)!=(0,0): ERR_SYNC=1; pixel emitted as (0,0).
//     Counters restart at (1,0); stay ACTIVE; FRAME_COUNT unchanged.
//   - SOF on the last pixel: takes the resync path, not frame completion.
//   - ACTIVE, RGB_VALID=0: counters hold; gaps of any length are allowed.
//  Latency:
//   - Exactly 1 cycle: pixel accepted at edge n appears on outputs after edge n+1.
//   - BAYER_VALID is the registered accept.
//  Channel select, p={Y[0]^PHASE[1], X[0]^PHASE[0]}:
//   - p=00 -> R; p=01 -> G; p=10 -> G; p=11 -> B.
//   - Even rows read R,G,R,G; odd rows read G,B,G,B.
//   - Values are passed unmodified; no arithmetic and no rounding.
//  Cycles with BAYER_VALID=0:
//   - BAYER_DATA is driven 0.
//   - BAYER_X/BAYER_Y hold their last values.
//  Error flag:
//   - ERR_CLR clears ERR_SYNC next cycle.
//   - Simultaneous set and ERR_CLR: set wins.
//  FRAME_COUNT wraps 0xFFFFF -> 0x00000 silently.
// TESTING
//  1. Reset, then RGB_VALID=1, RGB_SOF=0 for 10 cycles -> BAYER_VALID stays 0, FRAME_COUNT=0.
//  2. SOF + pixel R=0x111, G=0x222, B=0x333, then 3 more pixels, PHASE=0 ->
//     DATA 0x111,0x222,0x111,0x222; X=0..3, Y=0; each 1 cycle after input.
//  3. Full 800x600 frame with random RGB_VALID gaps:
//     - Line 1 data alternates G,B.
//     - Last output is X=799, Y=599.
//     - FRAME_COUNT=1; state returns to IDLE.
//  4. SOF injected at pixel (5,2):
//     - ERR_SYNC=1; that pixel is output at (0,0); next is (1,0).
//     - Frame completes normally; ERR_CLR pulse -> ERR_SYNC=0.
//  5. reset asserted at (400,300) -> next cycle all outputs 0.
//     A new SOF frame then completes with FRAME_COUNT=1.
//  6. PHASE=2'b11, pixel (0,0) -> BAYER_DATA=B; pixel (1,0) -> G.

Source files
------------

// File: rtl/rgb_to_bayer_mosaic_if.sv
// Pixel-stream bundle between an RGB source and the Bayer re-mosaic block.
// The slave side is the mosaic block; the master side is the RGB source and Bayer sink.
interface rgb_to_bayer_mosaic_if;
    logic [11:0] RGB_R;
    logic [11:0] RGB_G;
    logic [11:0] RGB_B;
    logic        RGB_VALID;
    logic        RGB_SOF;
    logic        ERR_CLR;
    logic [11:0] BAYER_DATA;
    logic [11:0] BAYER_X;
    logic [11:0] BAYER_Y;
    logic        BAYER_VALID;
    logic [11:0] BAYER_WIDTH;
    logic [11:0] BAYER_HEIGHT;
    logic [19:0] FRAME_COUNT;
    logic        ERR_SYNC;

    modport master (
        output RGB_R, RGB_G, RGB_B, RGB_VALID, RGB_SOF, ERR_CLR,
        input  BAYER_DATA, BAYER_X, BAYER_Y, BAYER_VALID,
               BAYER_WIDTH, BAYER_HEIGHT, FRAME_COUNT, ERR_SYNC
    );

    modport slave (
        input  RGB_R, RGB_G, RGB_B, RGB_VALID, RGB_SOF, ERR_CLR,
        output BAYER_DATA, BAYER_X, BAYER_Y, BAYER_VALID,
               BAYER_WIDTH, BAYER_HEIGHT, FRAME_COUNT, ERR_SYNC
    );
endinterface

// File: rtl/rgb_to_bayer_mosaic.sv
// Re-mosaics a raster RGB pixel stream into a 12-bit Bayer stream with X/Y
// coordinates, recovering frame sync from SOF and counting completed frames.
module rgb_to_bayer_mosaic #(
    parameter int unsigned VIDEO_W = 800,
    parameter int unsigned VIDEO_H = 600,
    parameter logic [1:0]  PHASE   = 2'b00
) (
    input logic                   BAYER_CLK,
    input logic                   reset,
    rgb_to_bayer_mosaic_if.slave  bus
);

    localparam logic [11:0] X_LAST = 12'(VIDEO_W - 1);
    localparam logic [11:0] Y_LAST = 12'(VIDEO_H - 1);

    typedef enum logic {IDLE, ACTIVE} state_t;

    state_t      state_q, state_d;
    logic [11:0] x_q, x_d;
    logic [11:0] y_q, y_d;
    logic [19:0] fc_q, fc_d;
    logic        err_q, err_d;
    logic [11:0] data_q, data_d;
    logic [11:0] ox_q, ox_d;
    logic [11:0] oy_q, oy_d;
    logic        valid_q, valid_d;

    logic        accept;
    logic        err_set;
    logic [11:0] emit_x;
    logic [11:0] emit_y;
    logic [1:0]  sel;

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        fc_d    = fc_q;
        accept  = 1'b0;
        err_set = 1'b0;
        emit_x  = x_q;
        emit_y  = y_q;
        if (bus.RGB_VALID) begin
            if (bus.RGB_SOF) begin
                // SOF always lands at (0,0); mid-frame it also flags a sync error.
                accept  = 1'b1;
                emit_x  = '0;
                emit_y  = '0;
                x_d     = 12'd1;
                y_d     = '0;
                state_d = ACTIVE;
                err_set = (state_q == ACTIVE) && ((x_q != '0) || (y_q != '0));
            end else if (state_q == ACTIVE) begin
                accept = 1'b1;
                if (x_q == X_LAST) begin
                    x_d = '0;
                    if (y_q == Y_LAST) begin
                        y_d     = '0;
                        fc_d    = fc_q + 20'd1;
                        state_d = IDLE;
                    end else begin
                        y_d = y_q + 12'd1;
                    end
                end else begin
                    x_d = x_q + 12'd1;
                end
            end
        end
    end

    always_comb begin
        sel    = {emit_y[0] ^ PHASE[1], emit_x[0] ^ PHASE[0]};
        data_d = '0;
        if (accept) begin
            case (sel)
                2'b00:   data_d = bus.RGB_R;
                2'b11:   data_d = bus.RGB_B;
                default: data_d = bus.RGB_G;
            endcase
        end
        ox_d    = accept ? emit_x : ox_q;
        oy_d    = accept ? emit_y : oy_q;
        valid_d = accept;
        err_d   = err_set ? 1'b1 : (bus.ERR_CLR ? 1'b0 : err_q);
    end

    always_ff @(posedge BAYER_CLK) begin
        if (reset) begin
            state_q <= IDLE;
            x_q     <= '0;
            y_q     <= '0;
            fc_q    <= '0;
            err_q   <= 1'b0;
            data_q  <= '0;
            ox_q    <= '0;
            oy_q    <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            fc_q    <= fc_d;
            err_q   <= err_d;
            data_q  <= data_d;
            ox_q    <= ox_d;
            oy_q    <= oy_d;
            valid_q <= valid_d;
        end
    end

    assign bus.BAYER_DATA   = data_q;
    assign bus.BAYER_X      = ox_q;
    assign bus.BAYER_Y      = oy_q;
    assign bus.BAYER_VALID  = valid_q;
    assign bus.BAYER_WIDTH  = 12'(VIDEO_W);
    assign bus.BAYER_HEIGHT = 12'(VIDEO_H);
    assign bus.FRAME_COUNT  = fc_q;
    assign bus.ERR_SYNC     = err_q;

endmodule

// File: tb/tb_rgb_to_bayer_mosaic.sv
// Randomized bench for rgb_to_bayer_mosaic: two instances (phase 00 and 11) share
// stimulus and are compared every cycle with a linear-pixel-index frame model.
module tb_rgb_to_bayer_mosaic;

    localparam int W = 20;
    localparam int H = 6;
    localparam int N = W * H;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    rgb_to_bayer_mosaic_if bus0 ();
    rgb_to_bayer_mosaic_if bus3 ();

    rgb_to_bayer_mosaic #(.VIDEO_W(W), .VIDEO_H(H), .PHASE(2'b00)) u_dut0 (
        .BAYER_CLK (clk),
        .reset     (rst),
        .bus       (bus0)
    );

    rgb_to_bayer_mosaic #(.VIDEO_W(W), .VIDEO_H(H), .PHASE(2'b11)) u_dut3 (
        .BAYER_CLK (clk),
        .reset     (rst),
        .bus       (bus3)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: frame position as a linear pixel index.
    bit          m_active = 0;
    int          m_pos    = 0;
    int          m_fc     = 0;
    bit          m_err    = 0;
    bit          e_valid  = 0;
    int          e_x      = 0;
    int          e_y      = 0;
    logic [11:0] e_data0  = '0;
    logic [11:0] e_data3  = '0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [11:0] bayer_pick(input int x, input int y, input logic [1:0] ph,
                                               input logic [11:0] r, input logic [11:0] g,
                                               input logic [11:0] b);
        int py = (y % 2) ^ int'(ph[1]);
        int px = (x % 2) ^ int'(ph[0]);
        if (py == 0 && px == 0) return r;
        if (py == 1 && px == 1) return b;
        return g;
    endfunction

    task automatic model(input logic r_rst, input logic v, input logic sof, input logic clr,
                         input logic [11:0] r, input logic [11:0] g, input logic [11:0] b);
        int  emit = -1;
        bit  set  = 0;
        if (r_rst) begin
            m_active = 0; m_pos = 0; m_fc = 0; m_err = 0;
            e_valid = 0; e_x = 0; e_y = 0; e_data0 = '0; e_data3 = '0;
            return;
        end
        if (v && sof) begin
            set = m_active && (m_pos != 0);
            emit = 0; m_pos = 1; m_active = 1;
        end else if (v && m_active) begin
            emit = m_pos;
            m_pos++;
            if (m_pos == N) begin
                m_pos = 0; m_active = 0; m_fc = (m_fc + 1) % (1 << 20);
            end
        end
        if (set) m_err = 1;
        else if (clr) m_err = 0;
        if (emit >= 0) begin
            e_valid = 1;
            e_x = emit % W;
            e_y = emit / W;
            e_data0 = bayer_pick(e_x, e_y, 2'b00, r, g, b);
            e_data3 = bayer_pick(e_x, e_y, 2'b11, r, g, b);
        end else begin
            e_valid = 0; e_data0 = '0; e_data3 = '0;
        end
    endtask

    task automatic step(input logic r_rst, input logic v, input logic sof, input logic clr,
                        input logic [11:0] r, input logic [11:0] g, input logic [11:0] b);
        rst = r_rst;
        bus0.RGB_R = r; bus0.RGB_G = g; bus0.RGB_B = b;
        bus0.RGB_VALID = v; bus0.RGB_SOF = sof; bus0.ERR_CLR = clr;
        bus3.RGB_R = r; bus3.RGB_G = g; bus3.RGB_B = b;
        bus3.RGB_VALID = v; bus3.RGB_SOF = sof; bus3.ERR_CLR = clr;
        model(r_rst, v, sof, clr, r, g, b);
        @(posedge clk);
        #1;
        check("valid0", 32'(bus0.BAYER_VALID), 32'(e_valid));
        check("data0",  32'(bus0.BAYER_DATA),  32'(e_data0));
        check("x0",     32'(bus0.BAYER_X),     32'(e_x));
        check("y0",     32'(bus0.BAYER_Y),     32'(e_y));
        check("fc0",    32'(bus0.FRAME_COUNT), 32'(m_fc));
        check("err0",   32'(bus0.ERR_SYNC),    32'(m_err));
        check("valid3", 32'(bus3.BAYER_VALID), 32'(e_valid));
        check("data3",  32'(bus3.BAYER_DATA),  32'(e_data3));
        check("x3",     32'(bus3.BAYER_X),     32'(e_x));
        check("y3",     32'(bus3.BAYER_Y),     32'(e_y));
        check("fc3",    32'(bus3.FRAME_COUNT), 32'(m_fc));
        check("err3",   32'(bus3.ERR_SYNC),    32'(m_err));
    endtask

    function automatic logic [11:0] rnd12();
        return 12'($urandom_range(0, 4095));
    endfunction

    task automatic idle(input logic clr);
        step(1'b0, 1'b0, 1'b0, clr, rnd12(), rnd12(), rnd12());
    endtask

    task automatic pixel(input logic sof, input logic clr, input int gap_max);
        int gaps = (gap_max > 0) ? $urandom_range(0, gap_max) : 0;
        for (int i = 0; i < gaps; i++) idle(1'b0);
        step(1'b0, 1'b1, sof, clr, rnd12(), rnd12(), rnd12());
    endtask

    task automatic run_to(input int pos, input int gap_max);
        for (int i = 0; i < N && m_active && m_pos != pos; i++) pixel(1'b0, 1'b0, gap_max);
        check("run_to_pos", 32'(m_pos), 32'(pos));
    endtask

    task automatic finish_frame(input int gap_max);
        for (int i = 0; i < N && m_active; i++) pixel(1'b0, 1'b0, gap_max);
        check("frame_done", 32'(m_active), 32'd0);
    endtask

    initial begin
        logic [11:0] exp0 [4];
        logic [11:0] exp3 [4];
        exp0 = '{12'h111, 12'h222, 12'h111, 12'h222};
        exp3 = '{12'h333, 12'h222, 12'h333, 12'h222};

        // Reset state and constant size outputs.
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 1'b0, '0, '0, '0);
        check("width",  32'(bus0.BAYER_WIDTH),  32'(W));
        check("height", 32'(bus0.BAYER_HEIGHT), 32'(H));

        // Pixels without SOF in IDLE are dropped.
        for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 1'b0, 1'b0, rnd12(), rnd12(), rnd12());
        check("idle_drop_valid", 32'(bus0.BAYER_VALID), 32'd0);
        check("idle_drop_fc",    32'(bus0.FRAME_COUNT), 32'd0);

        // Constant-colour start of frame: fixed data pattern per phase.
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b1, (i == 0), 1'b0, 12'h111, 12'h222, 12'h333);
            check("t2_data0", 32'(bus0.BAYER_DATA), 32'(exp0[i]));
            check("t2_data3", 32'(bus3.BAYER_DATA), 32'(exp3[i]));
            check("t2_x",     32'(bus0.BAYER_X),    32'(i));
        end

        // Rest of frame with random gaps.
        finish_frame(3);
        check("t3_last_x", 32'(bus0.BAYER_X), 32'(W - 1));
        check("t3_last_y", 32'(bus0.BAYER_Y), 32'(H - 1));
        check("t3_fc",     32'(bus0.FRAME_COUNT), 32'd1);
        idle(1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0, rnd12(), rnd12(), rnd12());
        check("t3_idle_after", 32'(bus0.BAYER_VALID), 32'd0);

        // Mid-frame SOF at (5,2), frame completion, then ERR_CLR.
        pixel(1'b1, 1'b0, 2);
        run_to(2 * W + 5, 2);
        pixel(1'b1, 1'b0, 0);
        check("t4_err", 32'(bus0.ERR_SYNC), 32'd1);
        check("t4_x",   32'(bus0.BAYER_X),  32'd0);
        check("t4_y",   32'(bus0.BAYER_Y),  32'd0);
        pixel(1'b0, 1'b0, 0);
        check("t4_next_x", 32'(bus0.BAYER_X), 32'd1);
        finish_frame(2);
        check("t4_fc", 32'(bus0.FRAME_COUNT), 32'd2);
        idle(1'b1);
        check("t4_clr", 32'(bus0.ERR_SYNC), 32'd0);

        // Simultaneous set and clear: set wins.
        pixel(1'b1, 1'b0, 1);
        run_to(7, 1);
        pixel(1'b1, 1'b1, 0);
        check("set_wins", 32'(bus0.ERR_SYNC), 32'd1);
        // SOF on the last pixel resyncs instead of completing.
        idle(1'b1);
        run_to(N - 1, 1);
        pixel(1'b1, 1'b0, 0);
        check("last_sof_fc",  32'(bus0.FRAME_COUNT), 32'd2);
        check("last_sof_err", 32'(bus0.ERR_SYNC),    32'd1);
        finish_frame(1);

        // Reset mid-frame abandons the frame; next frame counts from zero.
        pixel(1'b1, 1'b0, 1);
        run_to((H / 2) * W + W / 2, 1);
        step(1'b1, 1'b1, 1'b0, 1'b0, rnd12(), rnd12(), rnd12());
        check("t5_valid", 32'(bus0.BAYER_VALID), 32'd0);
        check("t5_data",  32'(bus0.BAYER_DATA),  32'd0);
        check("t5_x",     32'(bus0.BAYER_X),     32'd0);
        check("t5_fc",    32'(bus0.FRAME_COUNT), 32'd0);
        pixel(1'b1, 1'b0, 2);
        finish_frame(2);
        check("t5_fc_after", 32'(bus0.FRAME_COUNT), 32'd1);

        // Random traffic: gaps, stray SOFs, error clears, rare resets.
        for (int i = 0; i < 3000; i++) begin
            int dice = $urandom_range(0, 999);
            logic clr = ($urandom_range(0, 19) == 0);
            if (dice < 3)        step(1'b1, 1'b0, 1'b0, 1'b0, '0, '0, '0);
            else if (dice < 300) idle(clr);
            else if (dice < 320) pixel(1'b1, clr, 0);
            else if (!m_active && dice < 400) pixel(1'b1, clr, 0);
            else                 pixel(1'b0, clr, 0);
        end
        finish_frame(1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
